button_event_decoder: RTL and testbench

//   Consumes a clean, debounced button level and classifies it into one-cycle

---
 rtl/button_event_decoder.sv | 130 +++++++++++++
 tb/tb_button_event_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//   Turns a clean, debounced button level into one-cycle event pulses for menu
//   and control logic: press, release, short click, long press and auto-repeat
//   while the button stays held.
//
//   State table
//     state    | meaning
//     ---------+---------------------------------------------------------------
//     ST_IDLE  | button released, hold timer parked at 0
//     ST_SHORT | button held for less than LONG_CYCLES; release here is a click
//     ST_LONG  | long press recognised; repeat_pulse every REPEAT_CYCLES
//
// Ports
//   clk            in   system clock, all logic on posedge
//   rst_n          in   asynchronous active-low reset
//   btn_level      in   debounced button level, synchronous to clk, 1 = pressed
//   held           out  1 while state != ST_IDLE
//   press_pulse    out  one cycle on pressed edge
//   release_pulse  out  one cycle on released edge
//   click_pulse    out  one cycle on release from ST_SHORT
//   long_pulse     out  one cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   out  one cycle every REPEAT_CYCLES while in ST_LONG
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    logic             r_btn_q;
    logic [CNT_W-1:0] r_cnt;

    logic w_rise;
    logic w_fall;

    assign w_rise = btn_level & ~r_btn_q;
    assign w_fall = ~btn_level & r_btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_btn_q       <= 1'b0;
            r_cnt         <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            r_btn_q       <= btn_level;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state     <= ST_SHORT;
                        held        <= 1'b1;
                        press_pulse <= 1'b1;
                    end
                end

                // A release landing on the terminal count beats the long press.
                ST_SHORT: begin
                    if (w_fall) begin
                        r_state       <= ST_IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                        click_pulse   <= 1'b1;
                        r_cnt         <= '0;
                    end else if (r_cnt == LONG_TC) begin
                        r_state    <= ST_LONG;
                        long_pulse <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_LONG: begin
                    if (w_fall) begin
                        r_state       <= ST_IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                        r_cnt         <= '0;
                    end else if (r_cnt == REPEAT_TC) begin
                        repeat_pulse <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    held    <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//   Bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
//   Each pattern scenario derives its expected event list from the lengths of
//   the high runs in the stimulus (press one cycle after the first high sample,
//   long at press+8, repeats every 4 after that, release at press+run length)
//   and compares it with the events observed at the falling clock edges.
//   Event vector bit order: {held, press, release, click, long, repeat}.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_level;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         t;
        logic [5:0] m;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    button_event_decoder #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .held         (held),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] out_vec();
        return {held, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
    endfunction

    // Pushes the expected events of a pattern; pat[i] is driven for cycle i.
    task automatic push_expected(input logic [127:0] pat, input int n);
        logic [5:0] m [0:129];
        logic       prev;
        int         len;
        int         p;
        ev_t        e;
        for (int t = 0; t < 130; t++) m[t] = 6'b0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (pat[i] && !prev) begin
                len = 0;
                while (i + len < n && pat[i+len]) len++;
                p = i + 1;
                for (int t = p; t < p + len; t++) m[t][5] = 1'b1;
                m[p][4] = 1'b1;
                if (len >= 9) m[p+8][1] = 1'b1;
                for (int k = 1; p + 8 + 4*k < p + len; k++) m[p+8+4*k][0] = 1'b1;
                m[p+len][3] = 1'b1;
                if (len <= 8) m[p+len][2] = 1'b1;
            end
            prev = pat[i];
        end
        exp_q.delete();
        for (int t = 0; t <= n; t++) begin
            if (m[t] != 6'b0) begin
                e.t = t;
                e.m = m[t];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic apply_pattern(input logic [127:0] pat, input int n);
        ev_t e;
        obs_q.delete();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (out_vec() != 6'b0) begin
                e.t = i;
                e.m = out_vec();
                obs_q.push_back(e);
            end
            btn_level = (i < n) ? pat[i] : 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (held !== 1'b0)          begin n_errors++; $display("FAIL reset_held: got %b, expected 0", held); end
        n_checks++; if (press_pulse !== 1'b0)   begin n_errors++; $display("FAIL reset_press: got %b, expected 0", press_pulse); end
        n_checks++; if (release_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_release: got %b, expected 0", release_pulse); end
        n_checks++; if (click_pulse !== 1'b0)   begin n_errors++; $display("FAIL reset_click: got %b, expected 0", click_pulse); end
        n_checks++; if (long_pulse !== 1'b0)    begin n_errors++; $display("FAIL reset_long: got %b, expected 0", long_pulse); end
        n_checks++; if (repeat_pulse !== 1'b0)  begin n_errors++; $display("FAIL reset_repeat: got %b, expected 0", repeat_pulse); end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (out_vec() !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_idle: got %b, expected 000000", out_vec());
            end
        end
    endtask

    task automatic test_short_tap();
        logic [127:0] pat;
        ev_t e, o;
        pat = '0;
        for (int i = 1; i <= 3; i++) pat[i] = 1'b1;
        push_expected(pat, 8);
        apply_pattern(pat, 8);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL short_tap_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.t !== e.t || o.m !== e.m) begin
                n_errors++;
                $display("FAIL short_tap_event: got t=%0d v=%b, expected t=%0d v=%b", o.t, o.m, e.t, e.m);
            end
        end
    endtask

    task automatic test_long_hold();
        logic [127:0] pat;
        ev_t e, o;
        pat = '0;
        for (int i = 1; i <= 20; i++) pat[i] = 1'b1;
        push_expected(pat, 25);
        apply_pattern(pat, 25);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL long_hold_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.t !== e.t || o.m !== e.m) begin
                n_errors++;
                $display("FAIL long_hold_event: got t=%0d v=%b, expected t=%0d v=%b", o.t, o.m, e.t, e.m);
            end
        end
    endtask

    // Release sampled exactly when the hold timer sits at its terminal count,
    // then one cycle later (first cycle in LONG).
    task automatic test_terminal_release();
        logic [127:0] pat;
        ev_t e, o;
        for (int len = 8; len <= 9; len++) begin
            pat = '0;
            for (int i = 1; i <= len; i++) pat[i] = 1'b1;
            push_expected(pat, len + 5);
            apply_pattern(pat, len + 5);
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin
                n_errors++;
                $display("FAIL terminal_count_len%0d: got %0d events, expected %0d", len, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.t !== e.t || o.m !== e.m) begin
                    n_errors++;
                    $display("FAIL terminal_event_len%0d: got t=%0d v=%b, expected t=%0d v=%b", len, o.t, o.m, e.t, e.m);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pat;
        ev_t e, o;
        pat = '0;
        for (int k = 0; k < 4; k++) pat[1+2*k] = 1'b1;
        push_expected(pat, 11);
        apply_pattern(pat, 11);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL back_to_back_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.t !== e.t || o.m !== e.m) begin
                n_errors++;
                $display("FAIL back_to_back_event: got t=%0d v=%b, expected t=%0d v=%b", o.t, o.m, e.t, e.m);
            end
        end
    endtask

    task automatic test_reset_in_long();
        btn_level = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (held !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_pre_held: got %b, expected 1", held);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== 6'b0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got %b, expected 000000", out_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_vec() !== 6'b110000) begin
            n_errors++;
            $display("FAIL midreset_press: got %b, expected 110000", out_vec());
        end
        @(negedge clk);
        n_checks++;
        if (out_vec() !== 6'b100000) begin
            n_errors++;
            $display("FAIL midreset_held: got %b, expected 100000", out_vec());
        end
        btn_level = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_vec() !== 6'b001100) begin
            n_errors++;
            $display("FAIL midreset_release: got %b, expected 001100", out_vec());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_short_tap();
        test_long_hold();
        test_terminal_release();
        test_back_to_back();
        test_reset_in_long();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
